fifo_sync: RTL and testbench



---
 rtl/fifo_sync.sv | 94 +++++++++
 tb/tb_fifo_sync.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync.sv
`default_nettype none
// ============================================================================
// Module  : fifo_sync
// Brief   : Single-clock FIFO with chip-select gated strobes, registered read
//           data and combinational full/empty flags. Optional sticky
//           overflow/underflow outputs when FIFO_SYNC_ERR_FLAGS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_sync #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);

    logic [c_ADDR_W:0]     r_wr_ptr;
    logic [c_ADDR_W:0]     r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // Extra MSB on each pointer distinguishes full from empty when indices match.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]) &&
                   (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]);

    assign w_wr_acc = cs && wr_en && !full;
    assign w_rd_acc = cs && rd_en && !empty;

    assign data_out = r_data_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_data_out <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + {{c_ADDR_W{1'b0}}, 1'b1};
            end
            if (w_rd_acc) begin
                r_rd_ptr   <= r_rd_ptr + {{c_ADDR_W{1'b0}}, 1'b1};
                r_data_out <= r_mem[r_rd_ptr[c_ADDR_W-1:0]];
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_acc) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= data_in;
        end
    end

`ifdef FIFO_SYNC_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (cs && wr_en && full) begin
                r_overflow <= 1'b1;
            end
            if (cs && rd_en && empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_sync
// Brief   : Self-checking bench for fifo_sync: directed vector table, hand
//           sequences and random traffic against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_sync;

    localparam int DEPTH = 8;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    fifo_sync #(
        .FIFO_DEPTH (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full)
`ifdef FIFO_SYNC_ERR_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a plain queue of stored words plus the last read word.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_ovf  = 1'b0;
    logic          m_udf  = 1'b0;

    typedef struct {
        logic          rn;
        logic          c;
        logic          w;
        logic          r;
        logic [DW-1:0] d;
        logic [DW-1:0] dout;
        logic          e;
        logic          f;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic av(input logic rn, input logic c, input logic w, input logic r,
                      input logic [DW-1:0] d, input logic [DW-1:0] dout,
                      input logic e, input logic f);
        vec_t v;
        v = '{rn, c, w, r, d, dout, e, f};
        vecs.push_back(v);
    endtask

    // One clock: drive on the falling edge, sample 1ns after the rising edge.
    task automatic step(input logic rn, input logic c, input logic w, input logic r,
                        input logic [DW-1:0] d);
        bit wa;
        bit ra;
        @(negedge clk);
        rst_n   = rn;
        cs      = c;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        wa = c && w && (mq.size() < DEPTH);
        ra = c && r && (mq.size() != 0);
        @(posedge clk);
        #1;
        if (!rn) begin
            mq.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            if (c && w && mq.size() == DEPTH) m_ovf = 1'b1;
            if (c && r && mq.size() == 0)     m_udf = 1'b1;
            if (ra) m_dout = mq.pop_front();
            if (wa) mq.push_back(d);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".data_out"}, data_out, m_dout);
        check({tag, ".empty"}, {31'd0, empty}, {31'd0, mq.size() == 0});
        check({tag, ".full"},  {31'd0, full},  {31'd0, mq.size() == DEPTH});
`ifdef FIFO_SYNC_ERR_FLAGS_EN
        check({tag, ".overflow"},  {31'd0, overflow},  {31'd0, m_ovf});
        check({tag, ".underflow"}, {31'd0, underflow}, {31'd0, m_udf});
`endif
    endtask

    initial begin
        // Reset, then write 1/10/100 and read four times.
        av(0, 0, 0, 0, 0,   0,   1, 0);
        av(1, 1, 1, 0, 1,   0,   0, 0);
        av(1, 1, 1, 0, 10,  0,   0, 0);
        av(1, 1, 1, 0, 100, 0,   0, 0);
        av(1, 1, 0, 1, 0,   1,   0, 0);
        av(1, 1, 0, 1, 0,   10,  0, 0);
        av(1, 1, 0, 1, 0,   100, 1, 0);
        av(1, 1, 0, 1, 0,   100, 1, 0);
        // Interleaved write/read walking the pointers past the wrap point.
        for (int i = 0; i < 8; i++) begin
            av(1, 1, 1, 0, DW'(1 << i), (i == 0) ? DW'(100) : DW'(1 << (i - 1)), 0, 0);
            av(1, 1, 0, 1, 0, DW'(1 << i), 1, 0);
        end
        // Fill to full; ninth write must be dropped.
        for (int i = 0; i < 9; i++) begin
            av(1, 1, 1, 0, DW'(1 << i), 128, 0, (i >= 7));
        end
        // Full: simultaneous read/write returns oldest, write blocked.
        av(1, 1, 1, 1, 32'hDEAD, 1, 0, 0);
        for (int i = 1; i < 8; i++) begin
            av(1, 1, 0, 1, 0, DW'(1 << i), (i == 7), 0);
        end
        // Chip select low freezes everything.
        av(1, 1, 1, 0, 7,  128, 0, 0);
        av(1, 0, 1, 1, 55, 128, 0, 0);
        av(1, 0, 1, 1, 56, 128, 0, 0);
        av(1, 0, 1, 1, 57, 128, 0, 0);
        av(1, 1, 0, 1, 0,  7,   1, 0);

        foreach (vecs[k]) begin
            step(vecs[k].rn, vecs[k].c, vecs[k].w, vecs[k].r, vecs[k].d);
            check($sformatf("vec%0d.data_out", k), data_out, vecs[k].dout);
            check($sformatf("vec%0d.empty", k), {31'd0, empty}, {31'd0, vecs[k].e});
            check($sformatf("vec%0d.full", k),  {31'd0, full},  {31'd0, vecs[k].f});
`ifdef FIFO_SYNC_ERR_FLAGS_EN
            check($sformatf("vec%0d.model", k), data_out, m_dout);
`endif
        end
        check_model("after_table");

        // Reset takes priority over a concurrent read and write.
        step(1, 1, 1, 0, 32'h1111);
        step(1, 1, 1, 0, 32'h2222);
        step(1, 1, 0, 1, 0);
        check("pre_rst.data_out", data_out, 32'h1111);
        step(0, 1, 1, 1, 32'h3333);
        check("rst_prio.data_out", data_out, 0);
        check("rst_prio.empty", {31'd0, empty}, 32'd1);
        check("rst_prio.full",  {31'd0, full},  32'd0);
        step(1, 1, 0, 1, 0);
        check("rd_empty.data_out", data_out, 0);
        check("rd_empty.empty", {31'd0, empty}, 32'd1);
        check_model("after_rst");

        // Empty: simultaneous read/write accepts only the write (no fall-through).
        step(1, 1, 1, 1, 32'hCAFE);
        check("empty_rw.data_out", data_out, 0);
        check("empty_rw.empty", {31'd0, empty}, 32'd0);
        step(1, 1, 0, 1, 0);
        check("empty_rw.read", data_out, 32'hCAFE);

        // Random traffic with phases biased toward filling, draining, balance.
        for (int i = 0; i < 900; i++) begin
            int  ph;
            int  wp;
            int  rp;
            logic rn;
            ph = (i / 50) % 3;
            wp = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
            rp = 100 - wp;
            rn = ($urandom_range(0, 299) != 0);
            step(rn, ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
                 $urandom);
            check_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
